lsb_priority_arbiter: RTL

LSB_PRIORITY_ARBITER -- requirements
Module: lsb_priority_arbiter

---
 rtl/lsb_arb_pkg.sv | 29 ++
 rtl/lsb_pick_8x3.sv | 23 ++
 rtl/lsb_priority_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/lsb_arb_pkg.sv
// Shared sizes, FSM state type and vector helpers for the LSB-first request arbiter.
// Build option: LSB_ARB_ROUND_ROBIN_EN selects rotating search priority.
package lsb_arb_pkg;

    localparam int N_REQ = 8;
    localparam int ID_W  = 3;
    localparam int CNT_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] id);
        logic [N_REQ-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    // Rotate right so that bit 'sh' of the input lands at bit 0 of the result.
    function automatic logic [N_REQ-1:0] rotr(input logic [N_REQ-1:0] vec,
                                              input logic [ID_W-1:0]  sh);
        logic [2*N_REQ-1:0] dbl;
        dbl = {vec, vec} >> sh;
        return dbl[N_REQ-1:0];
    endfunction

endpackage

// File: rtl/lsb_pick_8x3.sv
// Combinational lowest-set-bit finder: 8-bit vector in, 3-bit index plus valid out.
// Bit 0 has the highest priority.
module lsb_pick_8x3
    import lsb_arb_pkg::*;
(
    input  logic [N_REQ-1:0] vec_i,
    output logic [ID_W-1:0]  idx_o,
    output logic             valid_o
);

    // Scan from the top down so the lowest set bit is the last to write idx_o.
    always_comb begin
        idx_o = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = ID_W'(i);
            end
        end
    end

    assign valid_o = |vec_i;

endmodule

// File: rtl/lsb_priority_arbiter.sv
// Eight-way arbiter with grant hold limit and timeout pulse; lowest request index wins.
// Build option: LSB_ARB_ROUND_ROBIN_EN rotates the search start past the last winner.
module lsb_priority_arbiter
    import lsb_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id,
    output logic             grant_valid,
    output logic             timeout,
    output arb_state_e       dbg_state
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    arb_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [N_REQ-1:0] grant_q;
    logic [ID_W-1:0]  grant_id_q;
    logic             grant_valid_q;
    logic             timeout_q;

    logic [N_REQ-1:0] search_vec;
    logic [ID_W-1:0]  pick_idx;
    logic             pick_valid;
    logic [ID_W-1:0]  grant_id_d;
    logic [N_REQ-1:0] grant_d;

`ifdef LSB_ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0]  ptr_q;

    // Index arithmetic is 3 bits wide, so adding the pointer back wraps 7->0.
    assign search_vec = rotr(req, ptr_q);
    assign grant_id_d = pick_idx + ptr_q;
`else
    assign search_vec = req;
    assign grant_id_d = pick_idx;
`endif

    assign grant_d = onehot(grant_id_d);

    lsb_pick_8x3 u_pick (
        .vec_i   (search_vec),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    logic owner_req;
    logic at_limit;
    logic release_now;
    logic forced;

    assign owner_req   = req[grant_id_q];
    assign at_limit    = (cnt_q == HOLD_LAST);
    assign release_now = done || !owner_req || at_limit;
    // A timeout is only reported when nothing else would have ended the grant.
    assign forced      = at_limit && !done && owner_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            grant_q       <= '0;
            grant_id_q    <= '0;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
`ifdef LSB_ARB_ROUND_ROBIN_EN
            ptr_q         <= '0;
`endif
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        state_q       <= BUSY;
                        grant_q       <= grant_d;
                        grant_id_q    <= grant_id_d;
                        grant_valid_q <= 1'b1;
                        cnt_q         <= '0;
`ifdef LSB_ARB_ROUND_ROBIN_EN
                        ptr_q         <= grant_id_d + 1'b1;
`endif
                    end
                end
                BUSY: begin
                    if (release_now) begin
                        state_q       <= IDLE;
                        grant_q       <= '0;
                        grant_id_q    <= '0;
                        grant_valid_q <= 1'b0;
                        cnt_q         <= '0;
                        timeout_q     <= forced;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant       = grant_q;
    assign grant_id    = grant_id_q;
    assign grant_valid = grant_valid_q;
    assign timeout     = timeout_q;
    assign dbg_state   = state_q;

    a_grant_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(grant_q));
    a_valid_matches : assert property (@(posedge clk) disable iff (!rst_n)
        grant_valid_q == (|grant_q));

endmodule
